// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predictor / recovery controller.
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
        else       return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Fetch / EX / recovery signal bundle between the core pipeline and branch_ctrl.
interface branch_ctrl_if #(parameter int PC_W = 10);

    logic            if_valid;
    logic [PC_W-1:0] if_pc;
    logic            if_pred_taken;

    logic            ex_valid;
    logic            ex_is_branch;
    logic [PC_W-1:0] ex_pc;
    logic            ex_pred_taken;
    logic            ex_mispredict;
    logic [PC_W-1:0] ex_target;

    logic            flush;
    logic            fetch_stall;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            busy;
    logic [15:0]     stat_branches;
    logic [15:0]     stat_mispredicts;

    modport slave (
        input  if_valid, if_pc, ex_valid, ex_is_branch, ex_pc, ex_pred_taken,
               ex_mispredict, ex_target,
        output if_pred_taken, flush, fetch_stall, redirect_valid, redirect_pc, busy,
               stat_branches, stat_mispredicts
    );

    modport master (
        output if_valid, if_pc, ex_valid, ex_is_branch, ex_pc, ex_pred_taken,
               ex_mispredict, ex_target,
        input  if_pred_taken, flush, fetch_stall, redirect_valid, redirect_pc, busy,
               stat_branches, stat_mispredicts
    );

endinterface

// File: rtl/bht_table.sv
// 2-bit saturating branch history table: one combinational read, one clocked update.
module bht_table
    import branch_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0] bht_q [ENTRIES];
    logic [1:0] bht_d [ENTRIES];

    always_comb begin
        bht_d = bht_q;
        if (wr_en) bht_d[wr_idx] = sat_update(bht_q[wr_idx], wr_taken);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) bht_q[i] <= WNT;
        end else begin
            bht_q <= bht_d;
        end
    end

    // Reads the registered array only, so a same-cycle update is not bypassed.
    assign rd_ctr = bht_q[rd_idx];

endmodule

// File: rtl/branch_ctrl.sv
// Branch prediction and mispredict recovery (flush -> redirect) controller.
// Optional resolve/mispredict counters are built when BRANCH_CTRL_STATS_EN is defined.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int PC_W         = 10,
    parameter int BHT_IDX_W    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    branch_ctrl_if.slave  bus
);

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [PC_W-1:0]       rpc_q, rpc_d;
    logic                  flush_q, flush_d;
    logic                  busy_q, busy_d;
    logic                  rv_q, rv_d;

    logic [BHT_IDX_W-1:0]  rd_idx, wr_idx;
    logic [1:0]            rd_ctr;
    logic                  resolve, taken;

    assign rd_idx  = bus.if_pc[BHT_IDX_W+1:2];
    assign wr_idx  = bus.ex_pc[BHT_IDX_W+1:2];
    // EX contents are wrong-path while recovering, so only IDLE resolves count.
    assign resolve = bus.ex_valid & bus.ex_is_branch & (state_q == IDLE);
    assign taken   = bus.ex_pred_taken ^ bus.ex_mispredict;

    bht_table #(.IDX_W(BHT_IDX_W)) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (rd_idx),
        .rd_ctr   (rd_ctr),
        .wr_en    (resolve),
        .wr_idx   (wr_idx),
        .wr_taken (taken)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpc_d   = rpc_q;
        case (state_q)
            IDLE: if (resolve && bus.ex_mispredict) begin
                state_d = FLUSH;
                cnt_d   = CNT_INIT;
                rpc_d   = bus.ex_target;
            end
            FLUSH: begin
                if (cnt_q == 3'd0) state_d = REDIRECT;
                else               cnt_d   = cnt_q - 3'd1;
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        flush_d = (state_d == FLUSH);
        rv_d    = (state_d == REDIRECT);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rpc_q   <= '0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rpc_q   <= rpc_d;
            flush_q <= flush_d;
            busy_q  <= busy_d;
            rv_q    <= rv_d;
        end
    end

    assign bus.if_pred_taken  = rd_ctr[1] & bus.if_valid;
    assign bus.flush          = flush_q;
    assign bus.fetch_stall    = busy_q;
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = rpc_q;
    assign bus.busy           = busy_q;

`ifdef BRANCH_CTRL_STATS_EN
    logic [15:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (resolve && br_cnt_q != 16'hFFFF) br_cnt_d = br_cnt_q + 16'd1;
        if (resolve && bus.ex_mispredict && mis_cnt_q != 16'hFFFF) mis_cnt_d = mis_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= 16'd0;
            mis_cnt_q <= 16'd0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign bus.stat_branches    = br_cnt_q;
    assign bus.stat_mispredicts = mis_cnt_q;
`else
    assign bus.stat_branches    = 16'd0;
    assign bus.stat_mispredicts = 16'd0;
`endif

    logic unused_bits;
    assign unused_bits = ^{bus.if_pc[PC_W-1:BHT_IDX_W+2], bus.if_pc[1:0],
                           bus.ex_pc[PC_W-1:BHT_IDX_W+2], bus.ex_pc[1:0], rd_ctr[0]};

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl; stat checks follow BRANCH_CTRL_STATS_EN.
module tb_branch_ctrl;

    localparam int PC_W = 10;
    localparam int IDX  = 4;
    localparam int FC   = 2;
`ifdef BRANCH_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_ctrl_if #(.PC_W(PC_W)) bus ();

    branch_ctrl #(.PC_W(PC_W), .BHT_IDX_W(IDX), .FLUSH_CYCLES(FC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic ifv; logic [9:0] ifpc; logic exv; logic br; logic [9:0] expc;
        logic pt;  logic mis;  logic [9:0] tgt;
    } stim_t;

    typedef struct packed {
        logic fl; logic st; logic rv; logic bz; logic pr; logic [9:0] rpc;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    function automatic stim_t mk_stim(input logic ifv, input logic [9:0] ifpc, input logic exv,
                                      input logic br, input logic [9:0] expc, input logic pt,
                                      input logic mis, input logic [9:0] tgt);
        return '{ifv, ifpc, exv, br, expc, pt, mis, tgt};
    endfunction

    function automatic exp_t mk_exp(input logic fl, input logic st, input logic rv,
                                    input logic bz, input logic pr, input logic [9:0] rpc);
        return '{fl, st, rv, bz, pr, rpc};
    endfunction

    task automatic drive(input stim_t s);
        bus.if_valid      = s.ifv;
        bus.if_pc         = s.ifpc;
        bus.ex_valid      = s.exv;
        bus.ex_is_branch  = s.br;
        bus.ex_pc         = s.expc;
        bus.ex_pred_taken = s.pt;
        bus.ex_mispredict = s.mis;
        bus.ex_target     = s.tgt;
    endtask

    task automatic push(input stim_t s, input exp_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // EX must hold a bubble in the first cycle back in IDLE after a redirect.
    logic rv_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rv_prev <= 1'b0;
        else begin
            if (rv_prev && bus.ex_valid && bus.ex_is_branch && bus.ex_mispredict)
                $error("FAIL post_redirect_bubble: mispredict seen in first IDLE cycle");
            rv_prev <= bus.redirect_valid;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        drive(mk_stim(1, 10'h010, 0, 0, 0, 0, 0, 0));
        #1;
        n_chk++;
        if ({bus.if_pred_taken, bus.flush, bus.fetch_stall, bus.redirect_valid, bus.busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {bus.if_pred_taken, bus.flush, bus.fetch_stall, bus.redirect_valid, bus.busy});
        end
        n_chk++;
        if ({bus.redirect_pc, bus.stat_branches, bus.stat_mispredicts} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got rpc=%h br=%h mis=%h want 0", bus.redirect_pc,
                     bus.stat_branches, bus.stat_mispredicts);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mispredict();
        stim_t m, mw, m2, i0;
        exp_t e, got;
        int step = 0;
        m  = mk_stim(1, 10'h010, 1, 1, 10'h010, 0, 1, 10'h024);
        mw = mk_stim(1, 10'h010, 1, 1, 10'h010, 0, 1, 10'h030);
        m2 = mk_stim(1, 10'h010, 1, 1, 10'h010, 0, 1, 10'h048);
        i0 = mk_stim(1, 10'h010, 0, 0, 0, 0, 0, 0);
        push(m,  mk_exp(0, 0, 0, 0, 0, 10'h000));
        push(mw, mk_exp(1, 1, 0, 1, 1, 10'h024));
        push(mw, mk_exp(1, 1, 0, 1, 1, 10'h024));
        push(mw, mk_exp(0, 1, 1, 1, 1, 10'h024));
        push(i0, mk_exp(0, 0, 0, 0, 1, 10'h024));
        push(m2, mk_exp(0, 0, 0, 0, 1, 10'h024));
        push(i0, mk_exp(1, 1, 0, 1, 1, 10'h048));
        push(i0, mk_exp(1, 1, 0, 1, 1, 10'h048));
        push(i0, mk_exp(0, 1, 1, 1, 1, 10'h048));
        push(i0, mk_exp(0, 0, 0, 0, 1, 10'h048));
        while (stim_q.size() > 0) begin
            @(negedge clk);
            drive(stim_q.pop_front());
            #1;
            e   = exp_q.pop_front();
            got = {bus.flush, bus.fetch_stall, bus.redirect_valid, bus.busy, bus.if_pred_taken, bus.redirect_pc};
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL mispredict step %0d: got fl/st/rv/bz/pr=%b rpc=%h want %b rpc=%h",
                         step, got[14:10], got.rpc, e[14:10], e.rpc);
            end
            step++;
        end
    endtask

    task automatic test_correct();
        stim_t c, n, nb, nv, i0;
        exp_t e, got;
        int step = 0;
        c  = mk_stim(1, 10'h010, 1, 1, 10'h010, 1, 0, 10'h200);
        n  = mk_stim(1, 10'h010, 1, 1, 10'h010, 1, 1, 10'h100);
        nb = mk_stim(1, 10'h010, 1, 0, 10'h010, 0, 1, 10'h300);
        nv = mk_stim(1, 10'h010, 0, 1, 10'h010, 0, 1, 10'h300);
        i0 = mk_stim(1, 10'h010, 0, 0, 0, 0, 0, 0);
        push(c,  mk_exp(0, 0, 0, 0, 1, 10'h048));
        push(i0, mk_exp(0, 0, 0, 0, 1, 10'h048));
        push(n,  mk_exp(0, 0, 0, 0, 1, 10'h048));
        push(i0, mk_exp(1, 1, 0, 1, 1, 10'h100));
        push(i0, mk_exp(1, 1, 0, 1, 1, 10'h100));
        push(i0, mk_exp(0, 1, 1, 1, 1, 10'h100));
        push(i0, mk_exp(0, 0, 0, 0, 1, 10'h100));
        push(nb, mk_exp(0, 0, 0, 0, 1, 10'h100));
        push(nv, mk_exp(0, 0, 0, 0, 1, 10'h100));
        push(i0, mk_exp(0, 0, 0, 0, 1, 10'h100));
        while (stim_q.size() > 0) begin
            @(negedge clk);
            drive(stim_q.pop_front());
            #1;
            e   = exp_q.pop_front();
            got = {bus.flush, bus.fetch_stall, bus.redirect_valid, bus.busy, bus.if_pred_taken, bus.redirect_pc};
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL correct step %0d: got fl/st/rv/bz/pr=%b rpc=%h want %b rpc=%h",
                         step, got[14:10], got.rpc, e[14:10], e.rpc);
            end
            step++;
        end
    endtask

    task automatic test_same_cycle();
        exp_t e, got;
        int step = 0;
        push(mk_stim(1, 10'h00C, 1, 1, 10'h00C, 1, 0, 0), mk_exp(0, 0, 0, 0, 0, 10'h100));
        push(mk_stim(1, 10'h00C, 0, 0, 0, 0, 0, 0),       mk_exp(0, 0, 0, 0, 1, 10'h100));
        push(mk_stim(1, 10'h04C, 0, 0, 0, 0, 0, 0),       mk_exp(0, 0, 0, 0, 1, 10'h100));
        push(mk_stim(0, 10'h00C, 0, 0, 0, 0, 0, 0),       mk_exp(0, 0, 0, 0, 0, 10'h100));
        push(mk_stim(1, 10'h010, 0, 0, 0, 0, 0, 0),       mk_exp(0, 0, 0, 0, 1, 10'h100));
        while (stim_q.size() > 0) begin
            @(negedge clk);
            drive(stim_q.pop_front());
            #1;
            e   = exp_q.pop_front();
            got = {bus.flush, bus.fetch_stall, bus.redirect_valid, bus.busy, bus.if_pred_taken, bus.redirect_pc};
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL same_cycle step %0d: got fl/st/rv/bz/pr=%b rpc=%h want %b rpc=%h",
                         step, got[14:10], got.rpc, e[14:10], e.rpc);
            end
            step++;
        end
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clk);
        drive(mk_stim(1, 10'h00C, 1, 1, 10'h00C, 0, 1, 10'h3F0));
        @(posedge clk);
        #1;
        drive(mk_stim(1, 10'h00C, 0, 0, 0, 0, 0, 0));
        n_chk++;
        if ({bus.flush, bus.busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_entry: got fl/bz=%b want 11", {bus.flush, bus.busy});
        end
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.flush, bus.fetch_stall, bus.redirect_valid, bus.busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL async_reset: got fl/st/rv/bz=%b want 0000",
                     {bus.flush, bus.fetch_stall, bus.redirect_valid, bus.busy});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if (bus.redirect_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL no_redirect cycle %0d: got %b want 0", i, bus.redirect_valid);
            end
        end
        rst_n = 1'b1;
        #1;
        n_chk++;
        if ({bus.if_pred_taken, bus.redirect_pc} !== 11'd0) begin
            n_fail++;
            $display("FAIL bht_reset_idx3: got pr=%b rpc=%h want 0/000", bus.if_pred_taken, bus.redirect_pc);
        end
        drive(mk_stim(1, 10'h010, 0, 0, 0, 0, 0, 0));
        #1;
        n_chk++;
        if (bus.if_pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL bht_reset_idx4: got %b want 0", bus.if_pred_taken);
        end
    endtask

    task automatic test_stats();
        logic [15:0] want_b, want_m;
        @(negedge clk) drive(mk_stim(1, 10'h020, 1, 1, 10'h020, 0, 0, 0));
        @(negedge clk) drive(mk_stim(1, 10'h020, 1, 1, 10'h020, 0, 0, 0));
        @(negedge clk) drive(mk_stim(1, 10'h020, 1, 1, 10'h020, 0, 1, 10'h0A0));
        // Wrong-path branch while flushing: must not be counted.
        @(negedge clk) drive(mk_stim(1, 10'h020, 1, 1, 10'h020, 0, 0, 0));
        @(negedge clk) drive(mk_stim(1, 10'h020, 0, 0, 0, 0, 0, 0));
        repeat (4) @(negedge clk);
        #1;
        want_b = STATS ? 16'd3 : 16'd0;
        want_m = STATS ? 16'd1 : 16'd0;
        n_chk++;
        if (bus.stat_branches !== want_b) begin
            n_fail++;
            $display("FAIL stat_branches: got %0d want %0d", bus.stat_branches, want_b);
        end
        n_chk++;
        if (bus.stat_mispredicts !== want_m) begin
            n_fail++;
            $display("FAIL stat_mispredicts: got %0d want %0d", bus.stat_mispredicts, want_m);
        end
`ifdef BRANCH_CTRL_STATS_EN
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk) drive(mk_stim(1, 10'h020, 1, 1, 10'h020, 0, 0, 0));
        end
        @(negedge clk) drive(mk_stim(1, 10'h020, 0, 0, 0, 0, 0, 0));
        #1;
        n_chk++;
        if (bus.stat_branches !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stat_branches_sat: got %h want ffff", bus.stat_branches);
        end
        @(negedge clk) drive(mk_stim(1, 10'h020, 1, 1, 10'h020, 0, 1, 10'h0B0));
        @(negedge clk) drive(mk_stim(1, 10'h020, 0, 0, 0, 0, 0, 0));
        repeat (5) @(negedge clk);
        #1;
        n_chk++;
        if ({bus.stat_branches, bus.stat_mispredicts} !== {16'hFFFF, 16'd2}) begin
            n_fail++;
            $display("FAIL stat_after_sat: got br=%h mis=%h want ffff/0002",
                     bus.stat_branches, bus.stat_mispredicts);
        end
`endif
    endtask

    initial begin
        drive(mk_stim(0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_mispredict();
        test_correct();
        test_same_cycle();
        test_reset_mid_flush();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
